// File: rtl/icb_ext_flat_buf_adapter.sv
// -----------------------------------------------------------------------------
// icb_ext_flat_buf_adapter
//
// Purpose:
//   Buffered, flow-controlled bridge between an MMA-side ICB ext master and the
//   flat ICB of top_sram_icb_bridge. The command, write-data and response
//   channels each go through a small FIFO. A beat-based credit counter only
//   lets a command out to the bridge if the response FIFO can hold every beat
//   that command will return. The block also keeps a sticky error flag.
//
// Handshake rule (all channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   Once valid is raised, it stays high with a stable payload until the
//   transfer. Every ready in this block comes straight from a register, so
//   no ready depends on a valid in the same cycle.
//
// Channel packing (the master-side structs are carried as flat vectors, MSB first):
//   icb_cmd_m : {valid, addr[M_ADDR_W-1:0], read, len[LEN_W-1:0]}
//   icb_wr_m  : {w_valid, wdata[WIDTH-1:0], wmask[MW-1:0]}
//   icb_cmd_s : ready
//   icb_wr_s  : w_ready
//   icb_rsp_s : {rsp_valid, rsp_rdata[WIDTH-1:0], rsp_err}
//   icb_rsp_m : rsp_ready
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   icb_cmd_m/_s        master command channel (address is cut to ADDR_W bits)
//   icb_wr_m/_s         master write-data channel
//   icb_rsp_s/_m        master response channel
//   sa_icb_cmd_*        flat command to the bridge (write data/mask taken from
//                       the head of the write FIFO)
//   sa_icb_w_valid/ready flat write-data handshake
//   sa_icb_rsp_*        flat response from the bridge
//   err_sticky/err_clr  sticky response-error flag and its synchronous clear
//   outs_beats          beats credited to the bridge and not yet popped by
//                       the master
// -----------------------------------------------------------------------------

// Generic FIFO with extended pointers (one extra wrap bit) and a registered
// ready. The ready register holds !full for the state after the current edge.
// This means a pop in the same cycle never frees space for a push in that
// cycle.
module icb_ext_flat_buf_fifo #(
  parameter int DW      = 8,
  parameter int DEPTH   = 2,
  parameter bit RDY_RST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_empty,
  output logic          o_ready
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_ready;

  logic          w_push;
  logic          w_pop;
  logic [PW:0]   w_wptr_nxt;
  logic [PW:0]   w_rptr_nxt;
  logic          w_full_nxt;

  assign o_empty    = (r_wptr == r_rptr);
  assign w_push     = i_push & r_ready;
  assign w_pop      = i_pop & ~o_empty;
  assign w_wptr_nxt = r_wptr + {{PW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{PW{1'b0}}, w_pop};
  // The FIFO is full when the wrap bits differ and the index bits are equal.
  assign w_full_nxt = (w_wptr_nxt[PW] != w_rptr_nxt[PW]) &&
                      (w_wptr_nxt[PW-1:0] == w_rptr_nxt[PW-1:0]);
  assign o_data     = r_mem[r_rptr[PW-1:0]];
  assign o_ready    = r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ready <= RDY_RST;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_ready <= ~w_full_nxt;
      if (w_push) begin
        r_mem[r_wptr[PW-1:0]] <= i_data;
      end
    end
  end
endmodule

module icb_ext_flat_buf_adapter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 19,
  parameter int LEN_W     = 3,
  parameter int MW        = WIDTH / 8,
  parameter int CMD_DEPTH = 2,
  parameter int WR_DEPTH  = 4,
  parameter int RSP_DEPTH = 8,
  // Width of the master-side address; it must be larger than ADDR_W.
  parameter int M_ADDR_W  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [M_ADDR_W+LEN_W+1:0]         icb_cmd_m,
  input  logic [WIDTH+MW:0]                 icb_wr_m,
  output logic                              icb_cmd_s,
  output logic                              icb_wr_s,
  output logic [WIDTH+1:0]                  icb_rsp_s,
  input  logic                              icb_rsp_m,
  output logic                              sa_icb_cmd_valid,
  input  logic                              sa_icb_cmd_ready,
  output logic [ADDR_W-1:0]                 sa_icb_cmd_addr,
  output logic                              sa_icb_cmd_read,
  output logic [LEN_W-1:0]                  sa_icb_cmd_len,
  output logic [WIDTH-1:0]                  sa_icb_cmd_wdata,
  output logic [MW-1:0]                     sa_icb_cmd_wmask,
  output logic                              sa_icb_w_valid,
  input  logic                              sa_icb_w_ready,
  input  logic                              sa_icb_rsp_valid,
  output logic                              sa_icb_rsp_ready,
  input  logic [WIDTH-1:0]                  sa_icb_rsp_rdata,
  input  logic                              sa_icb_rsp_err,
  output logic                              err_sticky,
  input  logic                              err_clr,
  output logic [$clog2(RSP_DEPTH+1)-1:0]    outs_beats
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  // Wide enough for outs_beats + (max len + 1) without any wrap.
  localparam int SUM_W = CNT_W + LEN_W + 1;
  localparam int CW    = ADDR_W + 1 + LEN_W;
  localparam int WW    = WIDTH + MW;
  localparam int RW    = WIDTH + 1;

  // ---------------------------------------------------------------- unpack
  logic              w_mcmd_valid;
  logic [ADDR_W-1:0] w_mcmd_addr;
  logic              w_mcmd_read;
  logic [LEN_W-1:0]  w_mcmd_len;
  logic              w_unused_addr_hi;

  assign w_mcmd_valid = icb_cmd_m[M_ADDR_W+LEN_W+1];
  assign w_mcmd_addr  = icb_cmd_m[ADDR_W+LEN_W:LEN_W+1];
  assign w_mcmd_read  = icb_cmd_m[LEN_W];
  assign w_mcmd_len   = icb_cmd_m[LEN_W-1:0];
  // The bridge address space is ADDR_W bits wide, so the upper address bits are dropped.
  assign w_unused_addr_hi = ^icb_cmd_m[M_ADDR_W+LEN_W:ADDR_W+LEN_W+1];

  // ---------------------------------------------------------- command path
  logic [CW-1:0]    w_cmd_head;
  logic             w_cmd_empty;
  logic             w_sa_cmd_fire;
  logic [SUM_W-1:0] w_need;
  logic             w_credit_ok;
  logic [CNT_W-1:0] r_outs;

  icb_ext_flat_buf_fifo #(
    .DW      (CW),
    .DEPTH   (CMD_DEPTH),
    .RDY_RST (1'b0)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_mcmd_valid),
    .i_data  ({w_mcmd_addr, w_mcmd_read, w_mcmd_len}),
    .i_pop   (w_sa_cmd_fire),
    .o_data  (w_cmd_head),
    .o_empty (w_cmd_empty),
    .o_ready (icb_cmd_s)
  );

  assign sa_icb_cmd_addr = w_cmd_head[CW-1 -: ADDR_W];
  assign sa_icb_cmd_read = w_cmd_head[LEN_W];
  assign sa_icb_cmd_len  = w_cmd_head[LEN_W-1:0];

  // Release the head command only when the response FIFO can hold all of its
  // beats on top of the beats still in flight. After that, the bridge can
  // never find the response FIFO full.
  assign w_need        = SUM_W'(r_outs) + SUM_W'(sa_icb_cmd_len) + SUM_W'(1);
  assign w_credit_ok   = (w_need <= SUM_W'(RSP_DEPTH));
  assign sa_icb_cmd_valid = ~w_cmd_empty & w_credit_ok;
  assign w_sa_cmd_fire = sa_icb_cmd_valid & sa_icb_cmd_ready;

  // ------------------------------------------------------- write-data path
  logic [WW-1:0] w_wr_head;
  logic          w_wr_empty;

  icb_ext_flat_buf_fifo #(
    .DW      (WW),
    .DEPTH   (WR_DEPTH),
    .RDY_RST (1'b0)
  ) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (icb_wr_m[WW]),
    .i_data  (icb_wr_m[WW-1:0]),
    .i_pop   (sa_icb_w_valid & sa_icb_w_ready),
    .o_data  (w_wr_head),
    .o_empty (w_wr_empty),
    .o_ready (icb_wr_s)
  );

  assign sa_icb_w_valid   = ~w_wr_empty;
  assign sa_icb_cmd_wdata = w_wr_head[WW-1 -: WIDTH];
  assign sa_icb_cmd_wmask = w_wr_head[MW-1:0];

  // --------------------------------------------------------- response path
  logic [RW-1:0] w_rsp_head;
  logic          w_rsp_empty;
  logic          w_rsp_pop;

  icb_ext_flat_buf_fifo #(
    .DW      (RW),
    .DEPTH   (RSP_DEPTH),
    .RDY_RST (1'b1)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (sa_icb_rsp_valid),
    .i_data  ({sa_icb_rsp_rdata, sa_icb_rsp_err}),
    .i_pop   (w_rsp_pop),
    .o_data  (w_rsp_head),
    .o_empty (w_rsp_empty),
    .o_ready (sa_icb_rsp_ready)
  );

  assign w_rsp_pop = ~w_rsp_empty & icb_rsp_m;
  assign icb_rsp_s = {~w_rsp_empty, w_rsp_head};

  // ------------------------------------------------------- credit counter
  logic [SUM_W-1:0] w_inc;
  logic [SUM_W-1:0] w_outs_nxt;

  assign w_inc      = w_sa_cmd_fire ? (SUM_W'(sa_icb_cmd_len) + SUM_W'(1)) : '0;
  assign w_outs_nxt = SUM_W'(r_outs) + w_inc - SUM_W'(w_rsp_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outs <= '0;
    end else begin
      r_outs <= w_outs_nxt[CNT_W-1:0];
    end
  end

  assign outs_beats = r_outs;

  // ---------------------------------------------------------- sticky error
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (err_clr) begin
      r_err <= 1'b0;                  // a clear takes priority over a new error in the same cycle
    end else if (w_rsp_pop && w_rsp_head[0]) begin
      r_err <= 1'b1;
    end
  end

  assign err_sticky = r_err;

  // ------------------------------------------------------------ assertions
  a_outs_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_outs_nxt <= SUM_W'(RSP_DEPTH));
  a_outs_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp_pop && !w_sa_cmd_fire && (r_outs == '0)));
endmodule

// File: tb/tb_icb_ext_flat_buf_adapter.sv
// Directed bench for icb_ext_flat_buf_adapter. A queue model follows each
// channel (command order, write-beat order, response order, credit count,
// sticky error) and checks the DUT on every falling edge. Directed checks with
// hand-computed values pin the model. The bench also plays the part of the
// bridge. It returns len+1 response beats for every command it accepts,
// starting one cycle after the accept.
module tb_icb_ext_flat_buf_adapter;
  localparam int WIDTH = 32, ADDR_W = 19, LEN_W = 3, MW = 4;
  localparam int CMD_DEPTH = 2, WR_DEPTH = 4, RSP_DEPTH = 8;

  logic        clk, rst_n;
  logic [36:0] icb_cmd_m;   // {valid, addr[31:0], read, len[2:0]}
  logic [36:0] icb_wr_m;    // {w_valid, wdata[31:0], wmask[3:0]}
  logic        icb_cmd_s, icb_wr_s, icb_rsp_m;
  logic [33:0] icb_rsp_s;   // {rsp_valid, rdata, err}
  logic        sa_icb_cmd_valid, sa_icb_cmd_ready, sa_icb_cmd_read;
  logic [18:0] sa_icb_cmd_addr;
  logic [2:0]  sa_icb_cmd_len;
  logic [31:0] sa_icb_cmd_wdata, sa_icb_rsp_rdata;
  logic [3:0]  sa_icb_cmd_wmask;
  logic        sa_icb_w_valid, sa_icb_w_ready;
  logic        sa_icb_rsp_valid, sa_icb_rsp_ready, sa_icb_rsp_err;
  logic        err_sticky, err_clr;
  logic [3:0]  outs_beats;

  icb_ext_flat_buf_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_m(icb_cmd_m), .icb_wr_m(icb_wr_m),
    .icb_cmd_s(icb_cmd_s), .icb_wr_s(icb_wr_s),
    .icb_rsp_s(icb_rsp_s), .icb_rsp_m(icb_rsp_m),
    .sa_icb_cmd_valid(sa_icb_cmd_valid), .sa_icb_cmd_ready(sa_icb_cmd_ready),
    .sa_icb_cmd_addr(sa_icb_cmd_addr), .sa_icb_cmd_read(sa_icb_cmd_read),
    .sa_icb_cmd_len(sa_icb_cmd_len), .sa_icb_cmd_wdata(sa_icb_cmd_wdata),
    .sa_icb_cmd_wmask(sa_icb_cmd_wmask),
    .sa_icb_w_valid(sa_icb_w_valid), .sa_icb_w_ready(sa_icb_w_ready),
    .sa_icb_rsp_valid(sa_icb_rsp_valid), .sa_icb_rsp_ready(sa_icb_rsp_ready),
    .sa_icb_rsp_rdata(sa_icb_rsp_rdata), .sa_icb_rsp_err(sa_icb_rsp_err),
    .err_sticky(err_sticky), .err_clr(err_clr), .outs_beats(outs_beats)
  );

  // ------------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [22:0] exp_cmd_q[$];    // {addr[18:0], read, len}
  logic [35:0] exp_wr_q[$];     // {wdata, wmask}
  logic [32:0] exp_rsp_q[$];    // {rdata, err}
  logic [18:0] sa_cmd_log[$];
  logic [31:0] sa_w_log[$];
  int          m_outs;
  logic        m_err, m_armed;
  logic        e_sa_valid;

  // handshake events seen on a falling edge, consumed by the bridge after the next rising edge
  logic        hs_cmd, hs_rsp;
  logic [2:0]  hs_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sa_cmd_valid", sa_icb_cmd_valid, 1'b0);
      chk("rst_sa_w_valid", sa_icb_w_valid, 1'b0);
      chk("rst_rsp_valid", icb_rsp_s[33], 1'b0);
      chk("rst_cmd_ready", icb_cmd_s, 1'b0);
      chk("rst_wr_ready", icb_wr_s, 1'b0);
      chk("rst_sa_rsp_ready", sa_icb_rsp_ready, 1'b1);
      chk("rst_outs", outs_beats, 4'd0);
      chk("rst_err", err_sticky, 1'b0);
      exp_cmd_q.delete(); exp_wr_q.delete(); exp_rsp_q.delete();
      m_outs = 0; m_err = 1'b0; m_armed = 1'b0;
      hs_cmd = 1'b0; hs_rsp = 1'b0; hs_len = '0;
    end else begin
      e_sa_valid = (exp_cmd_q.size() > 0) &&
                   (m_outs + int'(exp_cmd_q[0][2:0]) + 1 <= RSP_DEPTH);
      chk("cmd_ready", icb_cmd_s, m_armed && (exp_cmd_q.size() < CMD_DEPTH));
      chk("wr_ready", icb_wr_s, m_armed && (exp_wr_q.size() < WR_DEPTH));
      chk("sa_cmd_valid", sa_icb_cmd_valid, e_sa_valid);
      if (sa_icb_cmd_valid && exp_cmd_q.size() > 0)
        chk("sa_cmd_payload", {sa_icb_cmd_addr, sa_icb_cmd_read, sa_icb_cmd_len}, exp_cmd_q[0]);
      chk("sa_w_valid", sa_icb_w_valid, exp_wr_q.size() > 0);
      if (sa_icb_w_valid && exp_wr_q.size() > 0)
        chk("sa_w_payload", {sa_icb_cmd_wdata, sa_icb_cmd_wmask}, exp_wr_q[0]);
      chk("rsp_valid", icb_rsp_s[33], exp_rsp_q.size() > 0);
      if (icb_rsp_s[33] && exp_rsp_q.size() > 0)
        chk("rsp_payload", icb_rsp_s[32:0], exp_rsp_q[0]);
      chk("sa_rsp_ready", sa_icb_rsp_ready, exp_rsp_q.size() < RSP_DEPTH);
      chk("outs_beats", outs_beats, m_outs[3:0]);
      chk("err_sticky", err_sticky, m_err);

      // transfers that happen on the coming rising edge
      hs_cmd = sa_icb_cmd_valid && sa_icb_cmd_ready;
      hs_len = sa_icb_cmd_len;
      hs_rsp = sa_icb_rsp_valid && sa_icb_rsp_ready;
      if (hs_cmd && exp_cmd_q.size() > 0) begin
        m_outs += int'(exp_cmd_q[0][2:0]) + 1;
        sa_cmd_log.push_back(sa_icb_cmd_addr);
        void'(exp_cmd_q.pop_front());
      end
      if (icb_cmd_m[36] && icb_cmd_s)
        exp_cmd_q.push_back({icb_cmd_m[22:4], icb_cmd_m[3], icb_cmd_m[2:0]});
      if (sa_icb_w_valid && sa_icb_w_ready && exp_wr_q.size() > 0) begin
        sa_w_log.push_back(sa_icb_cmd_wdata);
        void'(exp_wr_q.pop_front());
      end
      if (icb_wr_m[36] && icb_wr_s)
        exp_wr_q.push_back(icb_wr_m[35:0]);
      if (icb_rsp_s[33] && icb_rsp_m && exp_rsp_q.size() > 0) begin
        m_outs -= 1;
        if (exp_rsp_q[0][0]) m_err = 1'b1;
        void'(exp_rsp_q.pop_front());
      end
      if (err_clr) m_err = 1'b0;
      if (hs_rsp) exp_rsp_q.push_back({sa_icb_rsp_rdata, sa_icb_rsp_err});
      m_armed = 1'b1;
    end
  end

  // ------------------------------------------------------ bridge model
  logic [32:0] br_q[$];   // {err, rdata}
  logic [31:0] br_base;
  logic        br_err, br_w_toggle;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      br_q.delete();
    end else begin
      if (hs_rsp && br_q.size() > 0) void'(br_q.pop_front());
      if (hs_cmd)
        for (int b = 0; b <= int'(hs_len); b++) br_q.push_back({br_err, br_base + 32'(b)});
    end
    sa_icb_w_ready   = br_w_toggle ? ~sa_icb_w_ready : 1'b1;
    sa_icb_rsp_valid = (br_q.size() > 0);
    sa_icb_rsp_err   = (br_q.size() > 0) ? br_q[0][32] : 1'b0;
    sa_icb_rsp_rdata = (br_q.size() > 0) ? br_q[0][31:0] : 32'h0;
  end

  // ---------------------------------------------------------- drivers
  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input logic [31:0] a, input logic rd, input logic [2:0] ln);
    logic acc;
    acc = 1'b0;
    icb_cmd_m = {1'b1, a, rd, ln};
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); acc = icb_cmd_s;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("cmd_accept_timeout", 1'b0, 1'b1);
    icb_cmd_m = '0;
  endtask

  task automatic send_wr(input logic [31:0] d, input logic [3:0] m);
    logic acc;
    acc = 1'b0;
    icb_wr_m = {1'b1, d, m};
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); acc = icb_wr_s;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("wr_accept_timeout", 1'b0, 1'b1);
    icb_wr_m = '0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(posedge clk); #1;
      idle = (exp_cmd_q.size() == 0) && (exp_wr_q.size() == 0) &&
             (exp_rsp_q.size() == 0) && (br_q.size() == 0) && (m_outs == 0);
    end
    chk("idle_reached", idle, 1'b1);
    chk("idle_outs_zero", outs_beats, 4'd0);
  endtask

  task automatic wait_rsp_valid(input string nm);
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (icb_rsp_s[33]) break;
    end
    chk(nm, icb_rsp_s[33], 1'b1);
  endtask

  // ----------------------------------------------------------- stimulus
  int  cyc;
  logic [18:0] bp_addr [3];

  initial begin
    rst_n = 1'b0; icb_cmd_m = '0; icb_wr_m = '0; icb_rsp_m = 1'b0; err_clr = 1'b0;
    sa_icb_cmd_ready = 1'b1; sa_icb_w_ready = 1'b1;
    sa_icb_rsp_valid = 1'b0; sa_icb_rsp_rdata = '0; sa_icb_rsp_err = 1'b0;
    br_base = '0; br_err = 1'b0; br_w_toggle = 1'b0;
    bp_addr[0] = 19'h00A10; bp_addr[1] = 19'h00B20; bp_addr[2] = 19'h00C30;
    repeat (3) @(posedge clk);
    chk("reset_cmd_ready_low", icb_cmd_s, 1'b0);
    chk("reset_sa_rsp_ready_high", sa_icb_rsp_ready, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_cmd_ready", icb_cmd_s, 1'b1);
    chk("post_reset_wr_ready", icb_wr_s, 1'b1);

    // Single read: the upper master address bits are dropped.
    icb_rsp_m = 1'b1; br_base = 32'hDEADBEEF;
    send_cmd(32'hABC00100, 1'b1, 3'd0);
    chk("single_sa_valid_1cyc", sa_icb_cmd_valid, 1'b1);
    chk("single_sa_addr", sa_icb_cmd_addr, 19'h00100);
    wait_rsp_valid("single_rsp_seen");
    chk("single_rdata", icb_rsp_s[32:1], 32'hDEADBEEF);
    chk("single_err", icb_rsp_s[0], 1'b0);
    wait_idle();

    // Credit stall: 4 + 4 beats fill the credit, so the third len=3 read waits.
    icb_rsp_m = 1'b0; br_base = 32'h00001000;
    send_cmd(32'h00000200, 1'b1, 3'd3);
    send_cmd(32'h00000300, 1'b1, 3'd3);
    send_cmd(32'h00000400, 1'b1, 3'd3);
    repeat (15) @(posedge clk); #1;
    chk("stall_outs", outs_beats, 4'd8);
    chk("stall_sa_valid", sa_icb_cmd_valid, 1'b0);
    chk("stall_rsp_fifo_full", sa_icb_rsp_ready, 1'b0);
    chk("stall_head_rdata", icb_rsp_s[32:1], 32'h00001000);
    icb_rsp_m = 1'b1;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk); #1;
      if (sa_icb_cmd_valid) break;
    end
    chk("release_seen", sa_icb_cmd_valid, 1'b1);
    chk("release_outs", outs_beats, 4'd4);
    chk("release_pops", cyc + 1, 4);
    wait_idle();

    // Write burst while the bridge w_ready toggles.
    sa_w_log.delete(); br_w_toggle = 1'b1;
    send_cmd(32'h00000500, 1'b0, 3'd3);
    for (int i = 1; i <= 4; i++) send_wr(32'(i), 4'hF);
    wait_idle();
    br_w_toggle = 1'b0;
    chk("wr_beat_count", sa_w_log.size(), 4);
    for (int i = 0; i < 4 && i < sa_w_log.size(); i++) chk("wr_beat_value", sa_w_log[i], 32'(i + 1));

    // Command backpressure: the FIFO takes 2 commands and the third waits.
    sa_cmd_log.delete(); sa_icb_cmd_ready = 1'b0;
    send_cmd({13'h0, bp_addr[0]}, 1'b1, 3'd0);
    send_cmd({13'h0, bp_addr[1]}, 1'b1, 3'd0);
    icb_cmd_m = {1'b1, {13'h0, bp_addr[2]}, 1'b1, 3'd0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_cmd_ready_low", icb_cmd_s, 1'b0);
    end
    sa_icb_cmd_ready = 1'b1;
    send_cmd({13'h0, bp_addr[2]}, 1'b1, 3'd0);
    wait_idle();
    chk("bp_issue_count", sa_cmd_log.size(), 3);
    for (int i = 0; i < 3 && i < sa_cmd_log.size(); i++) chk("bp_issue_order", sa_cmd_log[i], bp_addr[i]);

    // Error: the flag sets on the pop and holds. A clear in the same cycle as a new error wins.
    br_err = 1'b1;
    send_cmd(32'h00000600, 1'b1, 3'd0);
    wait_idle();
    chk("err_set", err_sticky, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("err_holds", err_sticky, 1'b1);
    icb_rsp_m = 1'b0;
    send_cmd(32'h00000700, 1'b1, 3'd0);
    wait_rsp_valid("err2_rsp_seen");
    chk("err2_rsp_err", icb_rsp_s[0], 1'b1);
    icb_rsp_m = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr_wins", err_sticky, 1'b0);
    br_err = 1'b0;
    wait_idle();

    // Reset with 3 beats outstanding, then a clean read.
    icb_rsp_m = 1'b0;
    send_cmd(32'h00000800, 1'b1, 3'd2);
    for (int t = 0; t < 50; t++) begin
      if (outs_beats == 4'd3) break;
      @(posedge clk); #1;
    end
    chk("midrst_outs_before", outs_beats, 4'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outs_async", outs_beats, 4'd0);
    chk("midrst_rsp_valid", icb_rsp_s[33], 1'b0);
    chk("midrst_sa_cmd_valid", sa_icb_cmd_valid, 1'b0);
    chk("midrst_sa_w_valid", sa_icb_w_valid, 1'b0);
    chk("midrst_cmd_ready", icb_cmd_s, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    icb_rsp_m = 1'b1; br_base = 32'h12345678;
    send_cmd(32'h00000040, 1'b1, 3'd0);
    wait_rsp_valid("clean_rsp_seen");
    chk("clean_rdata", icb_rsp_s[32:1], 32'h12345678);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
